// File: rtl/imm_encode.sv
// Two-stage immediate encoder: merges an immediate into a template instruction word.
// Optional range/alignment checking is built only when IMM_ENCODE_CHECK_EN is defined.
module imm_encode #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_fmt,
  input  logic [31:0]     i_base,
  input  logic [XLEN-1:0] i_imm,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instr,
  output logic            o_ovf,
  output logic            o_misalign
);

  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  // Reserved format codes fall through to the I-type layout.
  function automatic logic [31:0] encode(input logic [2:0] fmt, input logic [31:0] base,
                                         input logic [31:0] imm);
    logic [31:0] w;
    case (fmt)
      FMT_S:   w = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
      FMT_B:   w = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
      FMT_U:   w = {imm[31:12], base[11:0]};
      FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
      default: w = {imm[11:0], base[19:0]};
    endcase
    return w;
  endfunction

`ifdef IMM_ENCODE_CHECK_EN
  function automatic logic upper_same(input logic [XLEN-1:0] v, input int unsigned lsb);
    logic [XLEN-1:0] sh;
    sh = $signed(v) >>> lsb;
    return (sh == {XLEN{1'b0}}) || (sh == {XLEN{1'b1}});
  endfunction

  function automatic logic check_ovf(input logic [2:0] fmt, input logic [XLEN-1:0] imm);
    logic bad;
    case (fmt)
      FMT_B:   bad = !upper_same(imm, 32'd12);
      FMT_J:   bad = !upper_same(imm, 32'd20);
      FMT_U:   bad = (imm[11:0] != 12'd0) || !upper_same(imm, 32'd31);
      default: bad = !upper_same(imm, 32'd11);
    endcase
    return bad;
  endfunction
`endif

  logic            chk_ovf_s;
  logic            chk_mis_s;
  logic            s1_load_s;
  logic            s2_load_s;

  logic            s1_valid_d, s1_valid_q;
  logic [2:0]      s1_fmt_d,   s1_fmt_q;
  logic [31:0]     s1_base_d,  s1_base_q;
  logic [31:0]     s1_imm_d,   s1_imm_q;
  logic            s1_ovf_d,   s1_ovf_q;
  logic            s1_mis_d,   s1_mis_q;
  logic            s2_valid_d, s2_valid_q;
  logic [31:0]     s2_instr_d, s2_instr_q;
  logic            s2_ovf_d,   s2_ovf_q;
  logic            s2_mis_d,   s2_mis_q;

  // Range and alignment flags for the incoming request.
  always_comb begin
`ifdef IMM_ENCODE_CHECK_EN
    chk_ovf_s = check_ovf(i_fmt, i_imm);
    chk_mis_s = ((i_fmt == FMT_B) || (i_fmt == FMT_J)) && i_imm[0];
`else
    chk_ovf_s = 1'b0;
    chk_mis_s = 1'b0;
`endif
  end

  // Handshake: stage 2 frees when empty or draining, stage 1 when empty or advancing.
  always_comb begin
    s2_load_s = !s2_valid_q || i_ready;
    s1_load_s = !s1_valid_q || s2_load_s;
    o_ready   = s1_load_s;
  end

  // Stage 1 next state: capture request and check flags.
  always_comb begin
    if (s1_load_s) begin
      s1_valid_d = i_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s1_load_s && i_valid) begin
      s1_fmt_d  = i_fmt;
      s1_base_d = i_base;
      s1_imm_d  = i_imm[31:0];
      s1_ovf_d  = chk_ovf_s;
      s1_mis_d  = chk_mis_s;
    end else begin
      s1_fmt_d  = s1_fmt_q;
      s1_base_d = s1_base_q;
      s1_imm_d  = s1_imm_q;
      s1_ovf_d  = s1_ovf_q;
      s1_mis_d  = s1_mis_q;
    end
  end

  // Stage 2 next state: encoded word, held stable while stalled.
  always_comb begin
    if (s2_load_s) begin
      s2_valid_d = s1_valid_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (s2_load_s && s1_valid_q) begin
      s2_instr_d = encode(s1_fmt_q, s1_base_q, s1_imm_q);
      s2_ovf_d   = s1_ovf_q;
      s2_mis_d   = s1_mis_q;
    end else begin
      s2_instr_d = s2_instr_q;
      s2_ovf_d   = s2_ovf_q;
      s2_mis_d   = s2_mis_q;
    end
  end

  // Pipeline registers; reset drops anything in flight.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= 3'd0;
      s1_base_q  <= 32'd0;
      s1_imm_q   <= 32'd0;
      s1_ovf_q   <= 1'b0;
      s1_mis_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= 32'd0;
      s2_ovf_q   <= 1'b0;
      s2_mis_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_fmt_q   <= s1_fmt_d;
      s1_base_q  <= s1_base_d;
      s1_imm_q   <= s1_imm_d;
      s1_ovf_q   <= s1_ovf_d;
      s1_mis_q   <= s1_mis_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_mis_q   <= s2_mis_d;
    end
  end

  assign o_valid    = s2_valid_q;
  assign o_instr    = s2_instr_q;
  assign o_ovf      = s2_ovf_q;
  assign o_misalign = s2_mis_q;

endmodule
